serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 125 ++++++++++++
 tb/tb_serial_adder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell and a carry flop resolve WIDTH bits LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start is sampled high
// RUN   | one bit per cycle through the full-adder cell, WIDTH cycles
// DONE  | result registered, done strobe high; returns to IDLE unconditionally
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry_q;
    logic [CW-1:0]    cnt;

    logic             bit_s;
    logic             carry_nxt;
    logic             accept;
    logic             last_bit;

    always_comb begin
        bit_s     = a_sr[0] ^ b_sr[0] ^ carry_q;
        carry_nxt = (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & carry_q);
        accept    = (state == IDLE) && start;
        last_bit  = (state == RUN) && (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            a_sr    <= a;
            b_sr    <= b;
            sum_sr  <= '0;
            carry_q <= cin;
            cnt     <= '0;
        end else if (state == RUN) begin
            a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
            sum_sr  <= {bit_s, sum_sr[WIDTH-1:1]};
            carry_q <= carry_nxt;
            cnt     <= cnt + CW'(1);
        end
    end

    // busy trails the state by one edge so every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            busy <= (state == RUN);
            done <= last_bit;
            if (last_bit) begin
                sum  <= {bit_s, sum_sr[WIDTH-1:1]};
                cout <= carry_nxt;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the MSB cycle carry_q is the carry into the MSB and carry_nxt the carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last_bit) begin
            ovf <= carry_q ^ carry_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=13 against an a+b+cin model.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start8, cin8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        start13, cin13, busy13, done13, cout13;
    logic [12:0] a13, b13, sum13;
`ifdef SERIAL_ADDER_OVF_EN
    logic        ovf8, ovf13;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0]  held8  = '0;
    logic        heldc8 = 1'b0;
    logic [12:0] held13  = '0;
    logic        heldc13 = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8),
`ifdef SERIAL_ADDER_OVF_EN
        .cout(cout8), .ovf(ovf8)
`else
        .cout(cout8)
`endif
    );

    serial_adder #(.WIDTH(13)) dut13 (
        .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13), .cin(cin13),
        .busy(busy13), .done(done13), .sum(sum13),
`ifdef SERIAL_ADDER_OVF_EN
        .cout(cout13), .ovf(ovf13)
`else
        .cout(cout13)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic [31:0] av,
                         input logic [31:0] bv, input logic c);
        if (w == 8) begin
            start8 = st; a8 = av[7:0]; b8 = bv[7:0]; cin8 = c;
        end else begin
            start13 = st; a13 = av[12:0]; b13 = bv[12:0]; cin13 = c;
        end
    endtask

    function automatic logic [31:0] o_busy(input int w);
        return (w == 8) ? 32'(busy8) : 32'(busy13);
    endfunction
    function automatic logic [31:0] o_done(input int w);
        return (w == 8) ? 32'(done8) : 32'(done13);
    endfunction
    function automatic logic [31:0] o_sum(input int w);
        return (w == 8) ? 32'(sum8) : 32'(sum13);
    endfunction
    function automatic logic [31:0] o_cout(input int w);
        return (w == 8) ? 32'(cout8) : 32'(cout13);
    endfunction
`ifdef SERIAL_ADDER_OVF_EN
    function automatic logic [31:0] o_ovf(input int w);
        return (w == 8) ? 32'(ovf8) : 32'(ovf13);
    endfunction
`endif

    // Start one addition with the DUT idle; checks busy/done every cycle and the result at edge w.
    task automatic do_op(input int w, input logic [31:0] av, input logic [31:0] bv, input logic c);
        logic [32:0] full;
        logic [31:0] mask, exp_sum, exp_cout, exp_ovf;
        mask     = (32'd1 << w) - 32'd1;
        full     = {1'b0, av & mask} + {1'b0, bv & mask} + 33'(c);
        exp_sum  = full[31:0] & mask;
        exp_cout = 32'(full[w]);
        exp_ovf  = ((((av >> (w - 1)) & 1) == ((bv >> (w - 1)) & 1)) &&
                    (((exp_sum >> (w - 1)) & 1) != ((av >> (w - 1)) & 1))) ? 32'd1 : 32'd0;
        drive(w, 1'b1, av, bv, c);
        @(posedge clk); #1;
        drive(w, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
        check("busy_e0", o_busy(w), 0);
        check("done_e0", o_done(w), 0);
        for (int k = 1; k <= w; k++) begin
            @(posedge clk); #1;
            check("busy_run", o_busy(w), 1);
            check("done_run", o_done(w), (k == w) ? 1 : 0);
        end
        check("sum", o_sum(w), exp_sum);
        check("cout", o_cout(w), exp_cout);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", o_ovf(w), exp_ovf);
`else
        if (exp_ovf > 32'd1) $display("unreachable");
`endif
        @(posedge clk); #1;
        check("done_after", o_done(w), 0);
        check("busy_after", o_busy(w), 0);
    endtask

    // sum/cout may only change on an edge that also raises done.
    always @(negedge clk) begin
        if (rst_n && !done8) begin
            check("hold_sum8", 32'(sum8), 32'(held8));
            check("hold_cout8", 32'(cout8), 32'(heldc8));
        end
        if (rst_n && !done13) begin
            check("hold_sum13", 32'(sum13), 32'(held13));
            check("hold_cout13", 32'(cout13), 32'(heldc13));
        end
        held8   <= sum8;
        heldc8  <= cout8;
        held13  <= sum13;
        heldc13 <= cout13;
    end

    initial begin
        logic [7:0] av [40];
        logic [7:0] bv [40];
        logic [7:0] exp8;

        rst_n = 1'b0;
        drive(8, 1'b0, 0, 0, 1'b0);
        drive(13, 1'b0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy8), 0);
        check("rst_done", 32'(done8), 0);
        check("rst_sum", 32'(sum8), 0);
        check("rst_cout", 32'(cout8), 0);
        check("rst_sum13", 32'(sum13), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // directed cases
        do_op(8, 32'h3C, 32'h5A, 1'b0);
        check("t1_sum", 32'(sum8), 32'h96);
        check("t1_cout", 32'(cout8), 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("t1_ovf", 32'(ovf8), 1);
`endif
        do_op(8, 32'hFF, 32'h01, 1'b0);
        check("t2a_sum", 32'(sum8), 32'h00);
        check("t2a_cout", 32'(cout8), 1);
`ifdef SERIAL_ADDER_OVF_EN
        check("t2a_ovf", 32'(ovf8), 0);
`endif
        do_op(8, 32'h80, 32'h80, 1'b1);
        check("t2b_sum", 32'(sum8), 32'h01);
        check("t2b_cout", 32'(cout8), 1);
`ifdef SERIAL_ADDER_OVF_EN
        check("t2b_ovf", 32'(ovf8), 1);
`endif

        // start held high: accepted at cycles 0,10,20,30; operands elsewhere are ignored
        for (int i = 0; i < 40; i++) begin
            av[i] = 8'($urandom);
            bv[i] = 8'($urandom);
        end
        for (int i = 0; i < 40; i++) begin
            drive(8, 1'b1, 32'(av[i]), 32'(bv[i]), 1'b0);
            @(posedge clk); #1;
            check("hold_start_done", 32'(done8), (i % 10 == 8) ? 1 : 0);
            check("hold_start_busy", 32'(busy8), ((i % 10 >= 1) && (i % 10 <= 8)) ? 1 : 0);
            if (i % 10 == 8) begin
                exp8 = av[i-8] + bv[i-8];
                check("hold_start_sum", 32'(sum8), 32'(exp8));
            end
        end
        drive(8, 1'b0, 0, 0, 1'b0);

        // reset in the middle of a run
        do_op(8, 32'h70, 32'h21, 1'b1);
        drive(8, 1'b1, 32'h55, 32'h66, 1'b0);
        @(posedge clk); #1;
        drive(8, 1'b0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy8), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy8), 0);
        check("mid_rst_done", 32'(done8), 0);
        check("mid_rst_sum", 32'(sum8), 0);
        check("mid_rst_cout", 32'(cout8), 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("mid_rst_ovf", 32'(ovf8), 0);
`endif
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k == 2) rst_n = 1'b1;
            check("post_rst_done", 32'(done8), 0);
            check("post_rst_busy", 32'(busy8), 0);
        end
        do_op(8, 32'h01, 32'h01, 1'b0);
        check("after_rst_sum", 32'(sum8), 32'h02);

        // randomised operations on both widths
        for (int n = 0; n < 1000; n++)
            do_op(8, $urandom, $urandom, 1'($urandom_range(0, 1)));
        for (int n = 0; n < 1000; n++)
            do_op(13, $urandom, $urandom, 1'($urandom_range(0, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
